// File: rtl/reaction_measure.sv
// Reaction-timing core: waits a pseudo-random delay, lights the stimulus LED, then counts
// milliseconds until a valid sample reaches the threshold (or reports early / timeout).
module reaction_measure #(
    parameter int unsigned TICK_CYCLES  = 10000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned DELAY_MASK   = 1023,
    parameter int unsigned MAX_MS       = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] sample_data,
    input  logic       sample_valid,
    input  logic [7:0] threshold,
    output logic       led,
    output logic [9:0] result_ms,
    output logic       result_valid,
    output logic       early,
    output logic       timeout,
    output logic       busy,
    output logic [2:0] state
);
    localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TickW-1:0] TickMax   = TickW'(TICK_CYCLES - 1);
    localparam logic [10:0]      MinDelay  = 11'(MIN_DELAY_MS);
    localparam logic [9:0]       DelayMask = 10'(DELAY_MASK);
    localparam logic [9:0]       MaxMs     = 10'(MAX_MS);
    localparam logic [9:0]       MaxMsM1   = 10'(MAX_MS - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StStim  = 3'd2,
        StDone  = 3'd3,
        StEarly = 3'd4,
        StTout  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [10:0]      delay_cnt_q, delay_cnt_d;
    logic [9:0]       ms_cnt_q, ms_cnt_d;
    logic             led_q, led_d;
    logic [9:0]       result_ms_q, result_ms_d;
    logic             result_valid_q, result_valid_d;
    logic             early_q, early_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic tick, hit, start_edge;

    assign tick       = ena & (tick_cnt_q == TickMax);
    assign hit        = ena & sample_valid & (sample_data >= threshold);
    assign start_edge = ena & start & ~start_q;

    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        lfsr_d         = lfsr_q;
        tick_cnt_d     = tick_cnt_q;
        delay_cnt_d    = delay_cnt_q;
        ms_cnt_d       = ms_cnt_q;
        led_d          = led_q;
        result_ms_d    = result_ms_q;
        result_valid_d = result_valid_q;
        early_d        = early_q;
        timeout_d      = timeout_q;
        busy_d         = busy_q;

        if (ena) begin
            start_d        = start;
            lfsr_d         = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
            tick_cnt_d     = tick ? '0 : tick_cnt_q + 1'b1;
            result_valid_d = 1'b0;

            unique case (state_q)
                StArmed: begin
                    // A response before the stimulus beats a coincident delay expiry.
                    if (hit) begin
                        state_d = StEarly;
                        early_d = 1'b1;
                    end else if (tick) begin
                        if (delay_cnt_q == 11'd1) begin
                            state_d  = StStim;
                            led_d    = 1'b1;
                            ms_cnt_d = '0;
                        end else begin
                            delay_cnt_d = delay_cnt_q - 11'd1;
                        end
                    end
                end
                StStim: begin
                    if (hit) begin
                        state_d        = StDone;
                        result_ms_d    = ms_cnt_q;
                        result_valid_d = 1'b1;
                        led_d          = 1'b0;
                    end else if (tick) begin
                        if (ms_cnt_q == MaxMsM1) begin
                            state_d        = StTout;
                            timeout_d      = 1'b1;
                            result_ms_d    = MaxMs;
                            result_valid_d = 1'b1;
                            led_d          = 1'b0;
                        end else begin
                            ms_cnt_d = ms_cnt_q + 10'd1;
                        end
                    end
                end
                default: begin
                    if (start_edge) begin
                        state_d     = StArmed;
                        delay_cnt_d = MinDelay + {1'b0, lfsr_q[9:0] & DelayMask};
                        early_d     = 1'b0;
                        timeout_d   = 1'b0;
                    end
                end
            endcase

            // Restart the ms grid on every transition so the first tick is a full period away.
            if (state_d != state_q) begin
                tick_cnt_d = '0;
            end
            busy_d = (state_d == StArmed) || (state_d == StStim);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            start_q        <= 1'b0;
            lfsr_q         <= 16'hACE1;
            tick_cnt_q     <= '0;
            delay_cnt_q    <= '0;
            ms_cnt_q       <= '0;
            led_q          <= 1'b0;
            result_ms_q    <= '0;
            result_valid_q <= 1'b0;
            early_q        <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            lfsr_q         <= lfsr_d;
            tick_cnt_q     <= tick_cnt_d;
            delay_cnt_q    <= delay_cnt_d;
            ms_cnt_q       <= ms_cnt_d;
            led_q          <= led_d;
            result_ms_q    <= result_ms_d;
            result_valid_q <= result_valid_d;
            early_q        <= early_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign led          = led_q;
    assign result_ms    = result_ms_q;
    assign result_valid = result_valid_q;
    assign early        = early_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;
    assign state        = state_q;

endmodule

// File: tb/tb_reaction_measure.sv
// Scoreboard bench for reaction_measure: stimulus pushes expected outcomes, a monitor pops them.
module tb_reaction_measure;
    localparam int TICK  = 4;
    localparam int MIN_D = 2;
    localparam int MASK  = 3;
    localparam int MAXMS = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sample_data = 8'h00;
    logic       sample_valid = 1'b0;
    logic [7:0] threshold = 8'h80;
    logic       led, result_valid, early, timeout, busy;
    logic [9:0] result_ms;
    logic [2:0] state;

    reaction_measure #(
        .TICK_CYCLES (TICK),
        .MIN_DELAY_MS(MIN_D),
        .DELAY_MASK  (MASK),
        .MAX_MS      (MAXMS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .threshold   (threshold),
        .led         (led),
        .result_ms   (result_ms),
        .result_valid(result_valid),
        .early       (early),
        .timeout     (timeout),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    // kind: 0 = reaction result, 1 = early response, 2 = timeout
    typedef struct {
        int kind;
        int ms;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   en_cycles = 0;
    int   stim_n0 = 0;
    int   last_ms = 0;
    bit   early_prev = 1'b0;
    bit   rv_prev = 1'b0;

    // Enabled clock edges since reset: the LFSR position and the ms-tick time base.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_cycles <= 0;
        else if (ena) en_cycles <= en_cycles + 1;
    end

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] v = 16'hACE1;
        for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (rst_n) begin
            if (result_valid) check("result_valid_one_cycle", rv_prev, 0);
            if (result_valid || (early && !early_prev)) begin
                kind = result_valid ? (timeout ? 2 : 0) : 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got kind %0d, expected none", kind);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", kind, e.kind);
                    check("event_result_ms", result_ms, e.ms);
                    check("event_state", state, (e.kind == 0) ? 3 : (e.kind == 1) ? 4 : 5);
                    check("event_led_busy", {led, busy}, 0);
                end
            end
            early_prev = early;
            rv_prev    = result_valid;
        end else begin
            early_prev = 1'b0;
            rv_prev    = 1'b0;
        end
    end

    task automatic noise();
        sample_valid = 1'($urandom_range(0, 1));
        sample_data  = sample_valid ? 8'($urandom_range(0, 127)) : 8'($urandom_range(0, 255));
    endtask

    task automatic pulse_start(output int d);
        logic [15:0] l;
        start = 1'b0;
        @(negedge clk);
        l = lfsr_at(en_cycles);
        d = MIN_D + int'(l & 16'(MASK));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("armed_state", state, 1);
        check("armed_busy_led", {busy, led}, 2'b10);
        check("armed_flags_clear", {early, timeout}, 0);
    endtask

    task automatic wait_led(input int d, input bit glitch);
        int cnt = 1;
        while (!led && cnt < 40) begin
            if (glitch) start = ~start;
            noise();
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        sample_valid = 1'b0;
        check("stim_delay", cnt, 4 * d + 1);
        check("stim_state", state, 2);
        stim_n0 = en_cycles;
    endtask

    task automatic stim_hit(input int k, input bit glitch);
        int ms;
        for (int i = 0; i < k; i++) begin
            if (i == 0) begin
                sample_valid = 1'b1;
                sample_data  = 8'h7F;
            end else if (i == 1) begin
                sample_valid = 1'b0;
                sample_data  = 8'hFF;
            end else begin
                noise();
            end
            if (glitch) start = ~start;
            @(negedge clk);
        end
        start = 1'b0;
        sample_valid = 1'b1;
        sample_data  = (k % 3 == 0) ? 8'h80 : 8'($urandom_range(128, 255));
        ms = (en_cycles - stim_n0) / TICK;
        exp_q.push_back('{kind: 0, ms: ms});
        last_ms = ms;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_data  = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic early_run(input int j);
        int d;
        pulse_start(d);
        for (int i = 0; i < j; i++) begin
            noise();
            @(negedge clk);
        end
        sample_valid = 1'b1;
        sample_data  = 8'hFF;
        exp_q.push_back('{kind: 1, ms: last_ms});
        @(negedge clk);
        sample_valid = 1'b0;
        check("early_flag", early, 1);
        repeat (TICK * 6) @(negedge clk);
        check("early_led_never", led, 0);
        check("early_state_hold", state, 4);
        check("early_result_hold", result_ms, last_ms);
    endtask

    task automatic timeout_run();
        int d;
        int cnt = 0;
        pulse_start(d);
        wait_led(d, 1'b0);
        exp_q.push_back('{kind: 2, ms: MAXMS});
        while (!timeout && cnt < 100) begin
            noise();
            @(negedge clk);
            cnt++;
        end
        sample_valid = 1'b0;
        last_ms = MAXMS;
        check("timeout_latency", cnt, MAXMS * TICK);
        repeat (2) @(negedge clk);
        check("timeout_state", state, 5);
    endtask

    initial begin
        int d;
        repeat (3) @(negedge clk);
        check("reset_outputs", {led, result_ms, result_valid, early, timeout, busy, state}, 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {led, result_ms, result_valid, early, timeout, busy, state}, 0);

        pulse_start(d);
        wait_led(d, 1'b0);
        stim_hit(20, 1'b0);

        early_run(3);
        timeout_run();

        pulse_start(d);
        wait_led(d, 1'b0);
        stim_hit(15, 1'b0);

        // Freeze mid-STIM, then resume and finish.
        pulse_start(d);
        wait_led(d, 1'b0);
        repeat (6) begin
            noise();
            @(negedge clk);
        end
        sample_valid = 1'b0;
        ena = 1'b0;
        repeat (50) begin
            sample_valid = 1'b1;
            sample_data  = 8'hFF;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("freeze_state", state, 2);
        check("freeze_led_busy", {led, busy}, 2'b11);
        ena = 1'b1;
        stim_hit(5, 1'b0);

        // Reset mid-STIM.
        pulse_start(d);
        wait_led(d, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs",
              {led, result_ms, result_valid, early, timeout, busy, state}, 0);
        last_ms = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", state, 0);

        pulse_start(d);
        wait_led(d, 1'b1);
        stim_hit(9, 1'b1);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                early_run(int'($urandom_range(0, 6)));
            end else begin
                pulse_start(d);
                wait_led(d, 1'b0);
                stim_hit(int'($urandom_range(0, 79)), 1'b0);
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reaction_measure.md
Name: reaction_measure

Overview:
Reaction-timing core that consumes the byte sample stream produced by the SPI driver (data plus valid strobe). On a start request it waits a pseudo-random delay, raises a stimulus LED, then counts milliseconds until a sample meets or exceeds a programmable threshold. It reports the reaction time, an early-response fault or a timeout to the top-level output mux.

Parameters:
TICK_CYCLES, 10000, clk cycles per 1 ms tick (10 MHz clock)
MIN_DELAY_MS, 1000, fixed part of the random pre-stimulus delay, in ms
DELAY_MASK, 1023, mask applied to LFSR[9:0] for the random part of the delay
MAX_MS, 999, reaction count limit; reaching it means timeout

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; 0 freezes all state
start  input  1  start request, level input; rising edge is used
sample_data  input  8  sample byte from SPI driver
sample_valid  input  1  1-cycle strobe qualifying sample_data
threshold  input  8  hit threshold, unsigned
led  output  1  stimulus indicator
result_ms  output  10  last reaction time in ms
result_valid  output  1  1-cycle pulse when result_ms is updated
early  output  1  response arrived before stimulus
timeout  output  1  no response within MAX_MS
busy  output  1  high in ARMED or STIM
state  output  3  FSM state code for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE and all outputs 0. LFSR=16'hACE1; tick counter, delay counter and ms counter all 0; start edge register 0.
- ena=0: every register holds, including the LFSR. No tick, hit or start edge is recognised.
- start_edge: start registered once; edge = start & ~start_q. One cycle latency from the input.
- hit = sample_valid & (sample_data >= threshold). Equality counts as a hit. Data with sample_valid=0 is ignored.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400). Advances every cycle while ena=1. It can never reach 0.
- Tick: counter counts 0..TICK_CYCLES-1 and wraps. tick=1 on the cycle the count equals TICK_CYCLES-1. The counter clears on every state transition, so the first tick comes exactly TICK_CYCLES cycles after entering a state.
- State codes: IDLE=0, ARMED=1, STIM=2, DONE=3, EARLY=4, TOUT=5.
- IDLE / DONE / EARLY / TOUT:
  - start_edge -> ARMED. delay_cnt = MIN_DELAY_MS + (LFSR[9:0] & DELAY_MASK), width 11 bits.
  - early and timeout clear to 0 on this transition.
  - result_ms holds its last value.
- ARMED:
  - busy=1, led=0.
  - hit -> EARLY, early=1. hit has priority over delay expiry in the same cycle.
  - Otherwise each tick decrements delay_cnt. A tick with delay_cnt==1 -> STIM, led=1, ms_cnt=0.
  - start_edge is ignored.
- STIM:
  - busy=1, led=1.
  - hit -> DONE: result_ms=ms_cnt, result_valid=1 for one cycle, led=0.
  - hit on the same cycle as a tick: hit wins and ms_cnt is not incremented.
  - Otherwise each tick increments ms_cnt. A tick with ms_cnt==MAX_MS-1 -> TOUT: timeout=1, result_ms=MAX_MS, result_valid pulses, led=0.
  - start_edge is ignored.
- All outputs are registered; output changes appear the cycle after the causing input.
- Reset asserted mid-operation returns immediately to the reset values; no partial result is reported.

Test Plan:
(Bench parameters for all scenarios: TICK_CYCLES=4, MIN_DELAY_MS=2, DELAY_MASK=3, MAX_MS=20, threshold=8'h80.)
- Normal run: start edge, then sample 8'h80 valid 5 ticks (20 cycles) after led rises -> result_ms=5, result_valid high exactly 1 cycle, led=0, state=3; delay matches bench LFSR model (2..5 ticks).
- Early: start edge, sample 8'hFF valid during ARMED -> early=1, state=4, led never asserted, result_valid stays 0, result_ms unchanged.
- Timeout: start edge, no valid samples -> 20 ticks after led rises, timeout=1, result_ms=20, result_valid pulses, state=5; next start edge clears timeout and re-arms.
- Boundaries: in STIM, data 8'h7F valid -> no hit; data 8'hFF with sample_valid=0 -> no hit; data 8'h80 on a tick cycle after 3 ticks -> result_ms=3.
- Freeze: ena=0 for 50 cycles mid-STIM -> state, led, counters and LFSR unchanged; after ena=1, the result equals the pre-freeze count plus ticks counted after resume.
- Reset mid-STIM: rst_n low 2 cycles -> all outputs 0 immediately, state=0; start edge pulses during ARMED/STIM -> no restart.
